// File: rtl/bin_to_7seg_scan_if.sv
// ---------------------------------------------------------------------------
// bin_to_7seg_scan_if
// Purpose : Groups the value/handshake/display signals of bin_to_7seg_scan.
// Signals :
//   IN_i    [IN_W]   unsigned binary value to display        (master -> slave)
//   LOAD_i           start conversion, sampled only when idle (master -> slave)
//   BUSY_o           conversion in progress                  (slave -> master)
//   DONE_o           one-cycle pulse, new value latched      (slave -> master)
//   OVF_o            last latched value >= 10**N_DIG         (slave -> master)
//   SEG_o   [7]      segments {g,f,e,d,c,b,a}, bit0 = a      (slave -> master)
//   AN_o    [N_DIG]  one-hot digit enable, bit0 = LS digit   (slave -> master)
// ---------------------------------------------------------------------------
interface bin_to_7seg_scan_if #(
    parameter int unsigned IN_W  = 12,
    parameter int unsigned N_DIG = 4
);
    logic [IN_W-1:0]  IN_i;
    logic             LOAD_i;
    logic             BUSY_o;
    logic             DONE_o;
    logic             OVF_o;
    logic [6:0]       SEG_o;
    logic [N_DIG-1:0] AN_o;

    modport master (
        output IN_i, LOAD_i,
        input  BUSY_o, DONE_o, OVF_o, SEG_o, AN_o
    );

    modport slave (
        input  IN_i, LOAD_i,
        output BUSY_o, DONE_o, OVF_o, SEG_o, AN_o
    );
endinterface

// File: rtl/bin_to_7seg_scan.sv
// ---------------------------------------------------------------------------
// bin_to_7seg_scan
// Purpose : Sequential binary-to-7-segment driver. An iterative double-dabble
//           engine converts IN_i to N_DIG BCD digits, which are then
//           time-multiplexed onto one segment bus with a one-hot digit enable.
//           Supports leading-zero blanking, overflow dashes and output polarity.
// Ports   :
//   CLK_i   clock, all state on rising edge
//   RST_i   synchronous active-high reset
//   bus_if  bin_to_7seg_scan_if.slave (IN_i, LOAD_i, BUSY_o, DONE_o, OVF_o,
//           SEG_o, AN_o)
// ---------------------------------------------------------------------------
module bin_to_7seg_scan #(
    parameter int unsigned IN_W       = 12,
    parameter int unsigned N_DIG      = 4,
    parameter int unsigned SCAN_DIV   = 1000,
    parameter int unsigned BLANK_LZ   = 1,
    parameter int unsigned ACTIVE_LOW = 0
) (
    input  logic                CLK_i,
    input  logic                RST_i,
    bin_to_7seg_scan_if.slave   bus_if
);
    localparam int unsigned BCD_W  = 4 * N_DIG + 4;
    localparam int unsigned DISP_W = 4 * N_DIG;
    localparam int unsigned CNT_W  = $clog2(IN_W + 1);
    localparam int unsigned PRE_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W  = (N_DIG > 1) ? $clog2(N_DIG) : 1;

    // XOR masks that turn active-high "off" into the board polarity.
    localparam logic [6:0]       SEG_POL = (ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [N_DIG-1:0] AN_POL  = (ACTIVE_LOW != 0) ? '1 : '0;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH} state_t;

    state_t            state_q;
    logic [IN_W-1:0]   bin_q;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic              lost_q, lost_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [DISP_W-1:0] disp_q;
    logic              ovf_q, busy_q, done_q;
    logic [PRE_W-1:0]  presc_q;
    logic [IDX_W-1:0]  idx_q;
    logic [6:0]        seg_q, seg_d;
    logic [N_DIG-1:0]  an_q, an_d;

    function automatic logic [6:0] dec7(input logic [3:0] d);
        case (d)
            4'd0:    dec7 = 7'b0111111;
            4'd1:    dec7 = 7'b0000110;
            4'd2:    dec7 = 7'b1011011;
            4'd3:    dec7 = 7'b1001111;
            4'd4:    dec7 = 7'b1100110;
            4'd5:    dec7 = 7'b1101101;
            4'd6:    dec7 = 7'b1111101;
            4'd7:    dec7 = 7'b0000111;
            4'd8:    dec7 = 7'b1111111;
            4'd9:    dec7 = 7'b1101111;
            default: dec7 = 7'b0000000;
        endcase
    endfunction

    // One double-dabble step: add-3 correction on every nibble, then shift in
    // the next binary MSB. A bit leaving the extra nibble is remembered so
    // that very wide inputs on few digits still flag overflow.
    always_comb begin
        logic [BCD_W-1:0] adj;
        adj = bcd_q;
        for (int unsigned n = 0; n <= N_DIG; n++) begin
            if (bcd_q[4*n +: 4] >= 4'd5) adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
        end
        bcd_d  = {adj[BCD_W-2:0], bin_q[IN_W-1]};
        lost_d = adj[BCD_W-1];
    end

    // Segment/anode for the digit currently selected by the scan index.
    always_comb begin
        logic [3:0] digit;
        logic       upper_zero;
        logic [6:0] raw;
        logic [N_DIG-1:0] an_raw;
        digit      = '0;
        upper_zero = 1'b1;
        an_raw     = '0;
        for (int unsigned k = 0; k < N_DIG; k++) begin
            if (idx_q == IDX_W'(k)) begin
                digit     = disp_q[4*k +: 4];
                an_raw[k] = 1'b1;
            end
            if (k >= 32'(idx_q) && disp_q[4*k +: 4] != 4'd0) upper_zero = 1'b0;
        end
        if (ovf_q)
            raw = 7'b1000000;
        else if ((BLANK_LZ != 0) && (idx_q != '0) && upper_zero)
            raw = 7'b0000000;
        else
            raw = dec7(digit);
        seg_d = raw ^ SEG_POL;
        an_d  = an_raw ^ AN_POL;
    end

    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            state_q <= S_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            lost_q  <= 1'b0;
            cnt_q   <= '0;
            disp_q  <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            presc_q <= '0;
            idx_q   <= '0;
            seg_q   <= SEG_POL;
            an_q    <= AN_POL;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                // LATCH is the DONE cycle and behaves as idle for new loads.
                S_IDLE, S_LATCH: begin
                    state_q <= S_IDLE;
                    if (bus_if.LOAD_i) begin
                        bin_q   <= bus_if.IN_i;
                        bcd_q   <= '0;
                        lost_q  <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    bin_q  <= bin_q << 1;
                    bcd_q  <= bcd_d;
                    lost_q <= lost_q | lost_d;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    // Final shift latches straight from the step result so the
                    // display updates on the same edge DONE_o rises.
                    if (cnt_q == CNT_W'(IN_W - 1)) begin
                        disp_q  <= bcd_d[DISP_W-1:0];
                        ovf_q   <= lost_q | lost_d | (|bcd_d[BCD_W-1:DISP_W]);
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_LATCH;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            if (presc_q == PRE_W'(SCAN_DIV - 1)) begin
                presc_q <= '0;
                idx_q   <= (idx_q == IDX_W'(N_DIG - 1)) ? '0 : idx_q + IDX_W'(1);
            end else begin
                presc_q <= presc_q + PRE_W'(1);
            end

            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign bus_if.BUSY_o = busy_q;
    assign bus_if.DONE_o = done_q;
    assign bus_if.OVF_o  = ovf_q;
    assign bus_if.SEG_o  = seg_q;
    assign bus_if.AN_o   = an_q;
endmodule

// File: tb/tb_bin_to_7seg_scan.sv
// ---------------------------------------------------------------------------
// tb_bin_to_7seg_scan
// Purpose : Self-checking bench for bin_to_7seg_scan. Four instances cover
//           the default build, BLANK_LZ=0, N_DIG=3 and ACTIVE_LOW=1, all with
//           SCAN_DIV=4 so a full scan takes only a few cycles.
// ---------------------------------------------------------------------------
module tb_bin_to_7seg_scan;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int done0_cnt = 0;

    bin_to_7seg_scan_if #(.IN_W(12), .N_DIG(4)) b0 ();
    bin_to_7seg_scan_if #(.IN_W(12), .N_DIG(4)) b1 ();
    bin_to_7seg_scan_if #(.IN_W(12), .N_DIG(3)) b2 ();
    bin_to_7seg_scan_if #(.IN_W(12), .N_DIG(4)) b3 ();

    bin_to_7seg_scan #(.IN_W(12), .N_DIG(4), .SCAN_DIV(4), .BLANK_LZ(1), .ACTIVE_LOW(0))
        u0 (.CLK_i(clk), .RST_i(rst), .bus_if(b0));
    bin_to_7seg_scan #(.IN_W(12), .N_DIG(4), .SCAN_DIV(4), .BLANK_LZ(0), .ACTIVE_LOW(0))
        u1 (.CLK_i(clk), .RST_i(rst), .bus_if(b1));
    bin_to_7seg_scan #(.IN_W(12), .N_DIG(3), .SCAN_DIV(4), .BLANK_LZ(1), .ACTIVE_LOW(0))
        u2 (.CLK_i(clk), .RST_i(rst), .bus_if(b2));
    bin_to_7seg_scan #(.IN_W(12), .N_DIG(4), .SCAN_DIV(4), .BLANK_LZ(1), .ACTIVE_LOW(1))
        u3 (.CLK_i(clk), .RST_i(rst), .bus_if(b3));

    // Last segment pattern seen while each digit was enabled.
    logic [6:0] cap0[4], cap1[4], cap2[3], cap3[4];

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (b0.AN_o == 4'(1 << k))  cap0[k] = b0.SEG_o;
            if (b1.AN_o == 4'(1 << k))  cap1[k] = b1.SEG_o;
            if (b3.AN_o == ~4'(1 << k)) cap3[k] = b3.SEG_o;
        end
        for (int k = 0; k < 3; k++) begin
            if (b2.AN_o == 3'(1 << k)) cap2[k] = b2.SEG_o;
        end
        if (b0.DONE_o === 1'b1) done0_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_caps();
        for (int k = 0; k < 4; k++) begin
            cap0[k] = 'x; cap1[k] = 'x; cap3[k] = 'x;
        end
        for (int k = 0; k < 3; k++) cap2[k] = 'x;
    endtask

    // Waits (bounded) for DONE_o of the chosen instance; returns on that negedge.
    task automatic wait_done(input int which, output bit ok);
        logic d;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            case (which)
                0: d = b0.DONE_o;
                1: d = b1.DONE_o;
                2: d = b2.DONE_o;
                default: d = b3.DONE_o;
            endcase
            if (d === 1'b1) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        tick(3);
        n_checks++;
        if ({b0.BUSY_o, b0.DONE_o, b0.OVF_o} !== 3'b000) begin
            n_fail++; $display("FAIL rst_flags: got %b expected 000", {b0.BUSY_o, b0.DONE_o, b0.OVF_o});
        end
        n_checks++;
        if ({b0.SEG_o, b0.AN_o} !== 11'h000) begin
            n_fail++; $display("FAIL rst_off: got seg %b an %b expected 0000000/0000", b0.SEG_o, b0.AN_o);
        end
        n_checks++;
        if ({b3.SEG_o, b3.AN_o} !== 11'h7FF) begin
            n_fail++; $display("FAIL rst_off_al: got seg %b an %b expected 1111111/1111", b3.SEG_o, b3.AN_o);
        end
        rst = 1'b0;
        tick(1);
        n_checks++;
        if ({b0.AN_o, b0.SEG_o} !== {4'b0001, 7'b0111111}) begin
            n_fail++; $display("FAIL scan_first: got an %b seg %b expected 0001/0111111", b0.AN_o, b0.SEG_o);
        end
        n_checks++;
        if ({b3.AN_o, b3.SEG_o} !== {4'b1110, 7'b1000000}) begin
            n_fail++; $display("FAIL scan_first_al: got an %b seg %b expected 1110/1000000", b3.AN_o, b3.SEG_o);
        end
        tick(3);
        n_checks++;
        if (b0.AN_o !== 4'b0001) begin
            n_fail++; $display("FAIL scan_hold: got %b expected 0001", b0.AN_o);
        end
        tick(1);
        n_checks++;
        if ({b0.AN_o, b0.SEG_o} !== {4'b0010, 7'b0000000}) begin
            n_fail++; $display("FAIL scan_step: got an %b seg %b expected 0010/0000000", b0.AN_o, b0.SEG_o);
        end
        n_checks++;
        if (b1.SEG_o !== 7'b0111111) begin
            n_fail++; $display("FAIL scan_noblank: got %b expected 0111111", b1.SEG_o);
        end
        tick(12);
        n_checks++;
        if (b0.AN_o !== 4'b0001) begin
            n_fail++; $display("FAIL scan_wrap: got %b expected 0001", b0.AN_o);
        end
    endtask

    task automatic test_convert();
        logic [6:0] e[4];
        e = '{7'b1100110, 7'b1001111, 7'b1011011, 7'b0000110};
        b0.IN_i = 12'd1234; b0.LOAD_i = 1'b1;
        tick(1);
        b0.LOAD_i = 1'b0; b0.IN_i = 12'd0;
        for (int i = 1; i <= 12; i++) begin
            n_checks++;
            if ({b0.BUSY_o, b0.DONE_o} !== 2'b10) begin
                n_fail++; $display("FAIL conv_busy[%0d]: got busy/done %b expected 10", i, {b0.BUSY_o, b0.DONE_o});
            end
            tick(1);
        end
        n_checks++;
        if ({b0.BUSY_o, b0.DONE_o, b0.OVF_o} !== 3'b010) begin
            n_fail++; $display("FAIL conv_done: got busy/done/ovf %b expected 010", {b0.BUSY_o, b0.DONE_o, b0.OVF_o});
        end
        tick(1);
        n_checks++;
        if (b0.DONE_o !== 1'b0) begin
            n_fail++; $display("FAIL conv_pulse: got %b expected 0", b0.DONE_o);
        end
        clear_caps(); tick(20);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (cap0[k] !== e[k]) begin
                n_fail++; $display("FAIL conv_d%0d: got %b expected %b", k, cap0[k], e[k]);
            end
        end
    endtask

    task automatic test_blank();
        bit ok;
        logic [6:0] e0[4], e1[4];
        e0 = '{7'b0000111, 7'b0000000, 7'b0000000, 7'b0000000};
        e1 = '{7'b0000111, 7'b0111111, 7'b0111111, 7'b0111111};
        b0.IN_i = 12'd7; b0.LOAD_i = 1'b1;
        b1.IN_i = 12'd7; b1.LOAD_i = 1'b1;
        tick(1);
        b0.LOAD_i = 1'b0; b1.LOAD_i = 1'b0;
        wait_done(1, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL blank_timeout: got no DONE expected DONE"); end
        tick(2); clear_caps(); tick(20);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (cap0[k] !== e0[k]) begin
                n_fail++; $display("FAIL blank_lz_d%0d: got %b expected %b", k, cap0[k], e0[k]);
            end
            n_checks++;
            if (cap1[k] !== e1[k]) begin
                n_fail++; $display("FAIL noblank_d%0d: got %b expected %b", k, cap1[k], e1[k]);
            end
        end
    endtask

    task automatic test_overflow();
        bit ok;
        logic [11:0] vals[2];
        logic [6:0]  eseg[2];
        logic        eovf[2];
        vals = '{12'd1000, 12'd999};
        eseg = '{7'b1000000, 7'b1101111};
        eovf = '{1'b1, 1'b0};
        for (int t = 0; t < 2; t++) begin
            b2.IN_i = vals[t]; b2.LOAD_i = 1'b1;
            tick(1);
            b2.LOAD_i = 1'b0;
            wait_done(2, ok);
            n_checks++;
            if (!ok) begin n_fail++; $display("FAIL ovf_timeout[%0d]: got no DONE expected DONE", t); end
            n_checks++;
            if (b2.OVF_o !== eovf[t]) begin
                n_fail++; $display("FAIL ovf_flag[%0d]: got %b expected %b", t, b2.OVF_o, eovf[t]);
            end
            tick(2); clear_caps(); tick(20);
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (cap2[k] !== eseg[t]) begin
                    n_fail++; $display("FAIL ovf_d%0d[%0d]: got %b expected %b", k, t, cap2[k], eseg[t]);
                end
            end
        end
    endtask

    task automatic test_active_low();
        bit ok;
        b3.IN_i = 12'd8; b3.LOAD_i = 1'b1;
        tick(1);
        b3.LOAD_i = 1'b0;
        wait_done(3, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL al_timeout: got no DONE expected DONE"); end
        tick(2); clear_caps(); tick(20);
        n_checks++;
        if (cap3[0] !== 7'b0000000) begin
            n_fail++; $display("FAIL al_d0: got %b expected 0000000", cap3[0]);
        end
        n_checks++;
        if (cap3[1] !== 7'b1111111) begin
            n_fail++; $display("FAIL al_d1: got %b expected 1111111", cap3[1]);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int start;
        logic [6:0] e5[4], e42[4];
        e5  = '{7'b1101101, 7'b0000000, 7'b0000000, 7'b0000000};
        e42 = '{7'b1011011, 7'b1100110, 7'b0000000, 7'b0000000};
        start = done0_cnt;
        b0.IN_i = 12'd5; b0.LOAD_i = 1'b1;
        tick(1);
        b0.LOAD_i = 1'b0;
        tick(2);
        b0.IN_i = 12'd9; b0.LOAD_i = 1'b1;
        tick(1);
        b0.LOAD_i = 1'b0;
        wait_done(0, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL b2b_timeout: got no DONE expected DONE"); end
        tick(2); clear_caps(); tick(20);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (cap0[k] !== e5[k]) begin
                n_fail++; $display("FAIL b2b_ignore_d%0d: got %b expected %b", k, cap0[k], e5[k]);
            end
        end
        n_checks++;
        if (done0_cnt - start !== 1) begin
            n_fail++; $display("FAIL b2b_pulses: got %0d expected 1", done0_cnt - start);
        end
        // Load during the DONE cycle must be accepted.
        b0.IN_i = 12'd3; b0.LOAD_i = 1'b1;
        tick(1);
        b0.LOAD_i = 1'b0;
        wait_done(0, ok);
        b0.IN_i = 12'd42; b0.LOAD_i = 1'b1;
        tick(1);
        b0.LOAD_i = 1'b0; b0.IN_i = 12'd0;
        n_checks++;
        if (b0.BUSY_o !== 1'b1) begin
            n_fail++; $display("FAIL load_in_done: got busy %b expected 1", b0.BUSY_o);
        end
        wait_done(0, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL b2b_timeout2: got no DONE expected DONE"); end
        tick(2); clear_caps(); tick(20);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (cap0[k] !== e42[k]) begin
                n_fail++; $display("FAIL b2b_42_d%0d: got %b expected %b", k, cap0[k], e42[k]);
            end
        end
    endtask

    task automatic test_reset_abort();
        int start;
        logic [6:0] e0[4];
        e0 = '{7'b0111111, 7'b0000000, 7'b0000000, 7'b0000000};
        start = done0_cnt;
        b0.IN_i = 12'd8; b0.LOAD_i = 1'b1;
        tick(1);
        b0.LOAD_i = 1'b0;
        tick(5);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(25);
        n_checks++;
        if (done0_cnt - start !== 0) begin
            n_fail++; $display("FAIL abort_done: got %0d pulses expected 0", done0_cnt - start);
        end
        n_checks++;
        if (b0.BUSY_o !== 1'b0) begin
            n_fail++; $display("FAIL abort_busy: got %b expected 0", b0.BUSY_o);
        end
        clear_caps(); tick(20);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (cap0[k] !== e0[k]) begin
                n_fail++; $display("FAIL abort_d%0d: got %b expected %b", k, cap0[k], e0[k]);
            end
        end
    endtask

    initial begin
        b0.IN_i = '0; b0.LOAD_i = 1'b0;
        b1.IN_i = '0; b1.LOAD_i = 1'b0;
        b2.IN_i = '0; b2.LOAD_i = 1'b0;
        b3.IN_i = '0; b3.LOAD_i = 1'b0;
        test_reset();
        test_convert();
        test_blank();
        test_overflow();
        test_active_low();
        test_back_to_back();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
